// File: rtl/median_window_7.sv
// Sliding 7-sample window feeding the median/sort network; holds the last 7 accepted samples.
// Latency: one cycle registered; a sample accepted at edge t appears on win_6 after edge t.
// Backpressure: a full, unconsumed window deasserts in_ready; flush also holds in_ready low.
module median_window_7 #(
    parameter int WIDTH = 32,
    parameter int SEQ_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] win_0,
    output logic [WIDTH-1:0] win_1,
    output logic [WIDTH-1:0] win_2,
    output logic [WIDTH-1:0] win_3,
    output logic [WIDTH-1:0] win_4,
    output logic [WIDTH-1:0] win_5,
    output logic [WIDTH-1:0] win_6,
    output logic [SEQ_W-1:0] win_seq,
    output logic             filling
);

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       fill_cnt_q, fill_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [WIDTH-1:0] win_q [7];
    logic             accept;

    // Input is blocked while flushing or while a full window waits for the consumer.
    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign win_seq   = seq_q;
    assign win_0     = win_q[0];
    assign win_1     = win_q[1];
    assign win_2     = win_q[2];
    assign win_3     = win_q[3];
    assign win_4     = win_q[4];
    assign win_5     = win_q[5];
    assign win_6     = win_q[6];

    // Control state register; filling is registered alongside the state it mirrors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            fill_cnt_q  <= 3'd0;
            out_valid_q <= 1'b0;
            seq_q       <= '0;
            filling     <= 1'b1;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
            seq_q       <= seq_d;
            filling     <= (state_d == FILL);
        end
    end

    // Next-state logic: flush wins, then accept, then a bare consume drops out_valid.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = out_valid_q;
        seq_d       = seq_q;
        if (flush) begin
            state_d     = FILL;
            fill_cnt_d  = 3'd0;
            out_valid_d = 1'b0;
            seq_d       = '0;
        end else if (accept) begin
            case (state_q)
                FILL: begin
                    if (fill_cnt_q == 3'd6) begin
                        // Seventh sample completes the first window, which is numbered 0.
                        state_d     = STREAM;
                        fill_cnt_d  = 3'd7;
                        out_valid_d = 1'b1;
                        seq_d       = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 3'd1;
                    end
                end
                STREAM: begin
                    out_valid_d = 1'b1;
                    seq_d       = seq_q + 1'b1;
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Window shift register: oldest sample falls out of slot 0; contents survive flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 7; k++) begin
                win_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < 6; k++) begin
                win_q[k] <= win_q[k+1];
            end
            win_q[6] <= in_data;
        end
    end

endmodule

// File: tb/tb_median_window_7.sv
module tb_median_window_7;

    localparam int WIDTH = 32;
    localparam int SEQ_W = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6;
    logic [SEQ_W-1:0] win_seq;
    logic             filling;

    median_window_7 #(.WIDTH(WIDTH), .SEQ_W(SEQ_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .win_0    (win_0),
        .win_1    (win_1),
        .win_2    (win_2),
        .win_3    (win_3),
        .win_4    (win_4),
        .win_5    (win_5),
        .win_6    (win_6),
        .win_seq  (win_seq),
        .filling  (filling)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the last seven accepted samples (oldest first), number of
    // samples taken since reset/flush, whether a window is pending, and how many
    // windows have been produced since reset/flush.
    logic [WIDTH-1:0] m_win [7];
    int               m_cnt;
    bit               m_ov;
    int               m_nwin;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 7; k++) m_win[k] = '0;
        m_cnt  = 0;
        m_ov   = 0;
        m_nwin = 0;
    endtask

    function automatic logic [31:0] model_seq();
        if (m_nwin == 0) return 32'd0;
        return 32'((m_nwin - 1) % (1 << SEQ_W));
    endfunction

    task automatic check_outputs();
        logic [WIDTH-1:0] got [7];
        got = '{win_0, win_1, win_2, win_3, win_4, win_5, win_6};
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("filling", 32'(filling), 32'(m_cnt < 7));
        chk("win_seq", 32'(win_seq), model_seq());
        for (int k = 0; k < 7; k++) chk($sformatf("win_%0d", k), got[k], m_win[k]);
    endtask

    // One clock: drive inputs, check in_ready, clock, advance the model, check outputs.
    task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
        bit exp_rdy;
        bit acc;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = !fl && (!m_ov || ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        if (fl) begin
            m_cnt  = 0;
            m_ov   = 0;
            m_nwin = 0;
        end else if (acc) begin
            for (int k = 0; k < 6; k++) m_win[k] = m_win[k+1];
            m_win[6] = d;
            if (m_cnt < 7) m_cnt++;
            if (m_cnt == 7) begin
                m_ov = 1;
                m_nwin++;
            end
        end else if (m_ov && ordy) begin
            m_ov = 0;
        end
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        #12;
        check_outputs();
        chk("in_ready_rst", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with 10..70, then stream 80 and 90.
        for (int i = 1; i <= 9; i++) cycle(1, 32'(i * 10), 1, 0);
        chk("seq_after_90", 32'(win_seq), 32'd2);
        chk("win0_after_90", win_0, 32'd30);

        // Flush, refill 10..70, then hold the window for 5 cycles under backpressure.
        cycle(0, 0, 1, 1);
        for (int i = 1; i <= 7; i++) cycle(1, 32'(i * 10), 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 32'd99, 0, 0);
        chk("bp_hold_win6", win_6, 32'd70);
        cycle(1, 32'd99, 1, 0);
        chk("bp_release_win6", win_6, 32'd99);
        chk("bp_release_win0", win_0, 32'd20);

        // Flush while a window is pending, then 1..7 rebuilds a window.
        cycle(0, 0, 0, 1);
        for (int i = 1; i <= 7; i++) cycle(1, 32'(i), 1, 0);
        chk("refill_win0", win_0, 32'd1);

        // Stream 17+ windows so win_seq wraps through 15 back to 0.
        for (int i = 0; i < 17; i++) cycle(1, 32'(100 + i), 1, 0);
        chk("seq_wrapped", 32'(win_seq), 32'd1);

        // Asynchronous reset mid-fill after four samples.
        cycle(0, 0, 1, 1);
        for (int i = 1; i <= 4; i++) cycle(1, 32'(i + 200), 1, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) cycle(1, 32'(i + 300), 1, 0);
        chk("rst_refill_not_yet", 32'(out_valid), 32'd0);
        cycle(1, 32'd307, 1, 0);

        // Randomized traffic with occasional backpressure and flushes.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 60) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
